// File: rtl/quotient_table_pkg.sv
// quotient_table_pkg: shared geometry helpers and init-FSM state encodings
//   calc_lanes       - narrow entries per wide row
//   calc_waddr_width - wide row address width
package quotient_table_pkg;
    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] IDLE  = 1'b1;

    function automatic int calc_lanes(input int wbits, input int rbits);
        return 1 << (wbits - rbits);
    endfunction

    function automatic int calc_waddr_width(input int raw, input int wbits, input int rbits);
        return raw - (wbits - rbits);
    endfunction
endpackage

// File: rtl/quotient_table_mp_if.sv
// quotient_table_mp_if: write/read/control bundle of the quotient table
//   master drives clear_req, wen, waddr, wmask, wdata, ren, raddr
//   slave drives init_done, wready, rdata, rvalid
import quotient_table_pkg::*;

interface quotient_table_mp_if #(
    parameter int RDATA_WIDTH_BITS = 3,
    parameter int RADDR_WIDTH      = 4,
    parameter int WDATA_WIDTH_BITS = 6,
    parameter int NUM_RPORTS       = 2
) ();
    localparam int RW    = 1 << RDATA_WIDTH_BITS;
    localparam int WW    = 1 << WDATA_WIDTH_BITS;
    localparam int LANES = calc_lanes(WDATA_WIDTH_BITS, RDATA_WIDTH_BITS);
    localparam int WAW   = calc_waddr_width(RADDR_WIDTH, WDATA_WIDTH_BITS, RDATA_WIDTH_BITS);

    logic                          clear_req;
    logic                          init_done;
    logic                          wen;
    logic                          wready;
    logic [WAW-1:0]                waddr;
    logic [LANES-1:0]              wmask;
    logic [WW-1:0]                 wdata;
    logic [NUM_RPORTS-1:0]         ren;
    logic [NUM_RPORTS*RADDR_WIDTH-1:0] raddr;
    logic [NUM_RPORTS*RW-1:0]      rdata;
    logic [NUM_RPORTS-1:0]         rvalid;

    modport master (
        output clear_req, wen, waddr, wmask, wdata, ren, raddr,
        input  init_done, wready, rdata, rvalid
    );

    modport slave (
        input  clear_req, wen, waddr, wmask, wdata, ren, raddr,
        output init_done, wready, rdata, rvalid
    );
endinterface

// File: rtl/quotient_table_mp_rport.sv
// quotient_table_rport: one narrow read port over the flattened table
//   clock, reset_n - clock and async active-low reset
//   init_done_i    - table usable; gates rdata_o and rvalid_o
//   ren_i, raddr_i - read enable and narrow entry address
//   mem_i          - flattened table contents
//   rdata_o, rvalid_o - read data and valid
module quotient_table_rport #(
    parameter int RW           = 8,
    parameter int RADDR_WIDTH  = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             init_done_i,
    input  logic                             ren_i,
    input  logic [RADDR_WIDTH-1:0]           raddr_i,
    input  logic [(1<<RADDR_WIDTH)*RW-1:0]   mem_i,
    output logic [RW-1:0]                    rdata_o,
    output logic                             rvalid_o
);
    logic [RW-1:0] data;

    assign data = mem_i[raddr_i*RW +: RW];

    if (READ_LATENCY == 0) begin : g_comb
        assign rdata_o  = init_done_i ? data : '0;
        assign rvalid_o = ren_i & init_done_i;
    end else begin : g_reg
        logic [RW-1:0] rdata_q, rdata_d;
        logic          rvalid_q, rvalid_d;

        assign rdata_d  = ren_i ? data : rdata_q;
        assign rvalid_d = ren_i & init_done_i;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rdata_q  <= rdata_d;
                rvalid_q <= rvalid_d;
            end
        end

        // a clear entered after a read must hide the held word and its valid
        assign rdata_o  = init_done_i ? rdata_q : '0;
        assign rvalid_o = rvalid_q & init_done_i;
    end
endmodule

// File: rtl/quotient_table_mp.sv
// quotient_table_mp: wide-write / multi-narrow-read quotient table with self-clearing init
//   clock, reset_n - clock and async active-low reset
//   bus            - slave side of quotient_table_mp_if (write, read ports, clear control)
module quotient_table_mp
    import quotient_table_pkg::*;
#(
    parameter int RDATA_WIDTH_BITS = 3,
    parameter int RADDR_WIDTH      = 4,
    parameter int WDATA_WIDTH_BITS = 6,
    parameter int NUM_RPORTS       = 2,
    parameter int READ_LATENCY     = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    quotient_table_mp_if.slave bus
);
    localparam int RW    = 1 << RDATA_WIDTH_BITS;
    localparam int WW    = 1 << WDATA_WIDTH_BITS;
    localparam int LANES = calc_lanes(WDATA_WIDTH_BITS, RDATA_WIDTH_BITS);
    localparam int WAW   = calc_waddr_width(RADDR_WIDTH, WDATA_WIDTH_BITS, RDATA_WIDTH_BITS);
    localparam int DEPTH = 1 << RADDR_WIDTH;

    logic [0:0]              state_q, state_d;
    logic [WAW-1:0]          cnt_q, cnt_d;
    logic [RW-1:0]           mem_q [DEPTH];
    logic [DEPTH*RW-1:0]     mem_flat;
    logic                    clearing;
    logic                    init_done;
    logic [WAW-1:0]          row;
    logic [WW-1:0]           wd;
    logic [LANES-1:0]        wm;
    logic [NUM_RPORTS*RW-1:0] rdata_w;
    logic [NUM_RPORTS-1:0]   rvalid_w;

    assign clearing  = state_q == CLEAR;
    assign init_done = state_q == IDLE;

    // clear and user writes share one row port: clearing owns it with a full zero mask
    always_comb begin
        state_d = bus.clear_req ? CLEAR : (clearing && &cnt_q) ? IDLE : state_q;
        cnt_d   = (bus.clear_req || !clearing) ? '0 : cnt_q + 1'b1;
        row     = clearing ? cnt_q : bus.waddr;
        wd      = clearing ? '0 : bus.wdata;
        wm      = clearing ? '1 : (bus.wen ? bus.wmask : '0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < LANES; i++)
            if (wm[i]) mem_q[RADDR_WIDTH'(row * LANES + i)] <= wd[i*RW +: RW];
    end

    always_comb begin
        for (int e = 0; e < DEPTH; e++) mem_flat[e*RW +: RW] = mem_q[e];
    end

    for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
        quotient_table_rport #(
            .RW          (RW),
            .RADDR_WIDTH (RADDR_WIDTH),
            .READ_LATENCY(READ_LATENCY)
        ) u_rport (
            .clock      (clock),
            .reset_n    (reset_n),
            .init_done_i(init_done),
            .ren_i      (bus.ren[p]),
            .raddr_i    (bus.raddr[p*RADDR_WIDTH +: RADDR_WIDTH]),
            .mem_i      (mem_flat),
            .rdata_o    (rdata_w[p*RW +: RW]),
            .rvalid_o   (rvalid_w[p])
        );
    end

    assign bus.init_done = init_done;
    assign bus.wready    = init_done;
    assign bus.rdata     = rdata_w;
    assign bus.rvalid    = rvalid_w;
endmodule

// File: tb/tb_quotient_table_mp.sv
// tb_quotient_table_mp: directed test-plan cases plus random traffic against a table model
module tb_quotient_table_mp;
    localparam int RDB = 3, RAW = 4, WDB = 6, NP = 2, RL = 1;
    localparam int RW = 8, LANES = 8, ROWS = 2, DEPTH = 16;

    logic clock = 1'b0;
    logic reset_n;

    quotient_table_mp_if #(.RDATA_WIDTH_BITS(RDB), .RADDR_WIDTH(RAW),
                           .WDATA_WIDTH_BITS(WDB), .NUM_RPORTS(NP)) bus ();

    quotient_table_mp #(.RDATA_WIDTH_BITS(RDB), .RADDR_WIDTH(RAW), .WDATA_WIDTH_BITS(WDB),
                        .NUM_RPORTS(NP), .READ_LATENCY(RL)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    logic [7:0] mem_m [DEPTH];
    logic [7:0] er [NP];
    logic       ev [NP];
    int         clr_left;
    int         tests = 0;
    int         fails = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        clr_left = ROWS;
        for (int p = 0; p < NP; p++) begin
            er[p] = '0;
            ev[p] = 1'b0;
        end
    endtask

    // effect of one rising edge given the inputs currently applied
    task automatic model_edge();
        bit pre_init = clr_left == 0;
        for (int p = 0; p < NP; p++) begin
            if (bus.ren[p]) er[p] = mem_m[bus.raddr[p*RAW +: RAW]];
            ev[p] = bus.ren[p] && pre_init;
        end
        if (bus.wen && pre_init)
            for (int i = 0; i < LANES; i++)
                if (bus.wmask[i]) mem_m[bus.waddr * LANES + i] = bus.wdata[i*RW +: RW];
        if (clr_left > 0)
            for (int i = 0; i < LANES; i++) mem_m[(ROWS - clr_left) * LANES + i] = '0;
        if (bus.clear_req) clr_left = ROWS;
        else if (clr_left > 0) clr_left--;
    endtask

    task automatic check_all(input string tag);
        bit init = clr_left == 0;
        chk({tag, ".init_done"}, bus.init_done, init);
        chk({tag, ".wready"}, bus.wready, init);
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("%s.rdata%0d", tag, p), bus.rdata[p*RW +: RW], init ? er[p] : 8'h00);
            chk($sformatf("%s.rvalid%0d", tag, p), bus.rvalid[p], init && ev[p]);
        end
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    task automatic quiet();
        bus.clear_req = 0;
        bus.wen = 0;
        bus.waddr = '0;
        bus.wmask = '0;
        bus.wdata = '0;
        bus.ren = '0;
        bus.raddr = '0;
    endtask

    task automatic rd(input int p, input logic [3:0] a);
        bus.ren[p] = 1'b1;
        bus.raddr[p*RAW +: RAW] = a;
    endtask

    task automatic wr(input logic [0:0] a, input logic [7:0] m, input logic [63:0] d);
        bus.wen = 1;
        bus.waddr = a;
        bus.wmask = m;
        bus.wdata = d;
    endtask

    initial begin
        for (int e = 0; e < DEPTH; e++) mem_m[e] = '0;
        quiet();
        reset_n = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all("reset");
        reset_n = 1;

        // 1: clear after reset, then read entry F
        cycle("t1_clr0");
        cycle("t1_clr1");
        chk("t1_init", bus.init_done, 1'b1);
        rd(0, 4'hF);
        cycle("t1_read");
        chk("t1_rdF", bus.rdata[7:0], 8'h00);
        chk("t1_rv", bus.rvalid[0], 1'b1);
        quiet();

        // 2: full-row write, two ports read
        wr(1'b1, 8'hFF, 64'h0807060504030201);
        cycle("t2_wr");
        quiet();
        rd(0, 4'h8);
        rd(1, 4'hF);
        cycle("t2_rd");
        chk("t2_p0", bus.rdata[7:0], 8'h01);
        chk("t2_p1", bus.rdata[15:8], 8'h08);
        quiet();

        // 3: masked write on zeroed row 0
        wr(1'b0, 8'h05, 64'hAAAA_AAAA_AAAA_AAAA);
        cycle("t3_wr");
        quiet();
        for (int e = 0; e < 8; e += 2) begin
            rd(0, 4'(e));
            rd(1, 4'(e + 1));
            cycle("t3_rd");
            chk($sformatf("t3_e%0d", e), bus.rdata[7:0], (e == 0 || e == 2) ? 8'hAA : 8'h00);
            chk($sformatf("t3_e%0d", e + 1), bus.rdata[15:8], 8'h00);
        end
        quiet();

        // 4: read-before-write on the same entry
        rd(0, 4'h8);
        wr(1'b1, 8'h01, 64'h55);
        cycle("t4_rbw");
        chk("t4_old", bus.rdata[7:0], 8'h01);
        quiet();
        rd(0, 4'h8);
        cycle("t4_new");
        chk("t4_new", bus.rdata[7:0], 8'h55);
        quiet();

        // 5: clear request, dropped write, table zeroed
        bus.clear_req = 1;
        cycle("t5_req");
        quiet();
        chk("t5_wready", bus.wready, 1'b0);
        wr(1'b1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        cycle("t5_clr0");
        quiet();
        cycle("t5_clr1");
        chk("t5_init", bus.init_done, 1'b1);
        for (int e = 0; e < DEPTH; e += 2) begin
            rd(0, 4'(e));
            rd(1, 4'(e + 1));
            cycle("t5_rd");
            chk($sformatf("t5_e%0d", e), bus.rdata[15:0], 16'h0000);
        end
        quiet();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            bus.clear_req = $urandom_range(0, 39) == 0;
            bus.wen = 1'($urandom);
            bus.waddr = 1'($urandom);
            bus.wmask = 8'($urandom);
            bus.wdata = {$urandom, $urandom};
            bus.ren = 2'($urandom);
            bus.raddr = 8'($urandom);
            cycle("rand");
        end
        quiet();
        cycle("rand_tail");
        cycle("rand_tail");

        // 6: reset during the first clear cycle
        bus.clear_req = 1;
        cycle("t6_req");
        quiet();
        reset_n = 0;
        model_reset();
        #1;
        check_all("t6_rst");
        @(posedge clock);
        #1;
        check_all("t6_rst_hold");
        reset_n = 1;
        rd(0, {1'b1, 3'($urandom)});
        rd(1, {1'b1, 3'($urandom)});
        cycle("t6_clr0");
        chk("t6_rv0", bus.rvalid, 2'b00);
        chk("t6_init0", bus.init_done, 1'b0);
        cycle("t6_clr1");
        chk("t6_rv1", bus.rvalid, 2'b00);
        chk("t6_init1", bus.init_done, 1'b1);
        cycle("t6_read");
        chk("t6_rv2", bus.rvalid, 2'b11);
        quiet();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
